uart_rx_8n1: RTL and testbench

//   UART receiver, 8N1, LSB first; downstream consumer of the board's UART transmit line.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx_8n1.sv | 114 +++++++++++
 tb/tb_uart_rx_8n1.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx and tx blocks: frame geometry, board clocking, FSM states.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CLK_HZ    = 12_000_000;
    localparam int unsigned BAUD      = 9600;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_hw,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_hw) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling via a cycle counter, LSB first, one-cycle strobes for
// good bytes and framing errors.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic                 clk_hw,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned      CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0]  CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam int unsigned      IdxW    = $clog2(DATA_BITS);
    localparam logic [IdxW-1:0]  LastBit = IdxW'(DATA_BITS - 1);

    rx_state_e            state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk_hw (clk_hw),
        .rst_n  (rst_n),
        .d      (rx_pin),
        .q      (rx_s)
    );

    // busy is cleared from IDLE only, so it stays high through the rx_valid cycle and
    // drops on the cycle after.
    always_ff @(posedge clk_hw) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    busy <= ~rx_s;
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                StStart: begin
                    if (cnt == CntHalf) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= StData;
                            bit_idx <= '0;
                        end else begin
                            state <= StIdle;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == CntFull) begin
                        shreg[bit_idx] <= rx_s;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LastBit) begin
                            state <= StStop;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt == CntFull) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StBreak;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StBreak: begin
                    // A held-low line must not be mistaken for a stream of start bits.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at 16 clocks per bit: stimulus queues expected bytes,
// a negedge monitor checks every strobe and the held rx_data value.
module tb_uart_rx_8n1;

    localparam int unsigned CPB = 16;

    logic       clk_hw   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       drv_pin  = 1'b1;
    logic       tx_pin   = 1'b1;
    logic       loop_en  = 1'b0;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    assign rx_pin = loop_en ? tx_pin : drv_pin;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_hw    (clk_hw),
        .rst_n     (rst_n),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_hw = ~clk_hw;

    int cyc = 0;
    always @(posedge clk_hw) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         exp_ferr = 0;
    logic [7:0] model_data = 8'h00;
    int         last_valid_cyc = -1;
    int         prev_valid_cyc = -1;
    int         start_cyc = 0;
    bit         chk_busy_low = 1'b0;

    logic [7:0] tx_byte = 8'h00;
    bit         tx_go   = 1'b0;
    bit         tx_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_near(input string name, input int act, input int req, input int tol);
        n_checks++;
        if (act < req - tol || act > req + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks rx_data holds otherwise.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk_hw);
            if (!rst_n) begin
                model_data   = 8'h00;
                chk_busy_low = 1'b0;
            end else begin
                if (chk_busy_low) begin
                    check("busy_after_valid", busy, 0);
                    chk_busy_low = 1'b0;
                end
                if (rx_valid) begin
                    check("ferr_with_valid", frame_err, 0);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_rx_valid: got data 0x%0h, required no strobe",
                                 rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", rx_data, e);
                        check("busy_at_valid", busy, 1);
                        model_data = e;
                    end
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                    chk_busy_low   = 1'b1;
                end else begin
                    check("rx_data_stable", rx_data, model_data);
                end
                if (frame_err) begin
                    n_checks++;
                    if (exp_ferr == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_frame_err: got 1, required 0 (cycle %0d)", cyc);
                    end else begin
                        exp_ferr--;
                    end
                end
            end
        end
    end

    // Bench-side serializer standing in for the tx block in the loopback case.
    initial begin
        logic [9:0] fr;
        forever begin
            @(posedge clk_hw);
            if (tx_go && !tx_done) begin
                fr = {1'b1, tx_byte, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    #1 tx_pin = fr[i];
                    repeat (CPB) @(posedge clk_hw);
                end
                tx_done = 1'b1;
            end
        end
    end

    task automatic set_bit(input logic v);
        #1 drv_pin = v;
        repeat (CPB) @(posedge clk_hw);
    endtask

    // Caller must be at a posedge; returns on the posedge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        if (stop) exp_q.push_back(d);
        else exp_ferr++;
        start_cyc = cyc;
        set_bit(1'b0);
        for (int i = 0; i < 8; i++) set_bit(d[i]);
        set_bit(stop);
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && exp_ferr == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_hw);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes/%0d errs pending, required 0",
                     name, exp_q.size(), exp_ferr);
            exp_q.delete();
            exp_ferr = 0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_hw);
        @(negedge clk_hw);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        @(posedge clk_hw);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk_hw);

        // 1: single frame 0x9A with latency check
        send_frame(8'h9A, 1'b1);
        wait_drain("t1");
        check_near("latency_9a", last_valid_cyc - start_cyc, 155, 2);
        repeat (20) @(posedge clk_hw);

        // 2: back-to-back 0x00, 0xFF with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("t2");
        check_near("b2b_gap", last_valid_cyc - prev_valid_cyc, 160, 2);
        repeat (20) @(posedge clk_hw);

        // 3: 4-cycle glitch must be rejected at the start-bit check
        #1 drv_pin = 1'b0;
        repeat (4) @(posedge clk_hw);
        #1 drv_pin = 1'b1;
        repeat (3) @(posedge clk_hw);
        @(negedge clk_hw);
        check("glitch_busy_high", busy, 1);
        repeat (20) @(posedge clk_hw);
        @(negedge clk_hw);
        check("glitch_busy_low", busy, 0);
        @(posedge clk_hw);

        // 4: 0x55 with low stop bit, line held low 40 cycles, then 0x3C
        send_frame(8'h55, 1'b0);
        repeat (20) @(posedge clk_hw);
        @(negedge clk_hw);
        check("ferr_seen", exp_ferr, 0);
        check("break_busy", busy, 1);
        @(posedge clk_hw);
        repeat (3) @(posedge clk_hw);
        #1 drv_pin = 1'b1;
        repeat (6) @(posedge clk_hw);
        @(negedge clk_hw);
        check("break_exit_busy", busy, 0);
        repeat (16) @(posedge clk_hw);
        send_frame(8'h3C, 1'b1);
        wait_drain("t4");
        repeat (20) @(posedge clk_hw);

        // 5: reset pulse during bit 4 of 0xA5, then 0x5A
        set_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a5 = 8'hA5;
            set_bit(a5[i]);
        end
        #1 drv_pin = 1'b0;
        repeat (8) @(posedge clk_hw);
        #1 rst_n = 1'b0;
        @(posedge clk_hw);
        #1 rst_n = 1'b1;
        drv_pin = 1'b1;
        @(negedge clk_hw);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_busy", busy, 0);
        repeat (200) @(posedge clk_hw);
        send_frame(8'h5A, 1'b1);
        wait_drain("t5");
        repeat (20) @(posedge clk_hw);

        // 6: loopback from the serializer
        loop_en = 1'b1;
        tx_byte = 8'h9A;
        exp_q.push_back(8'h9A);
        tx_go = 1'b1;
        for (int i = 0; i < 300 && !tx_done; i++) @(posedge clk_hw);
        check("loopback_tx_done", tx_done, 1);
        wait_drain("t6");
        repeat (20) @(posedge clk_hw);
        check("final_model_data", model_data, 8'h9A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
